// File: rtl/simon_pkg.sv
// Shared SIMON definitions: z-sequences, FSM state codes, and width-generic rotate/round helpers.
package simon_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_KLOAD = 4'd1,
        ST_KEXP  = 4'd2,
        ST_DLOAD = 4'd3,
        ST_ROUND = 4'd4,
        ST_DONE  = 4'd5
    } state_t;

    // Leftmost character of each literal is z[0].
    localparam logic [61:0] Z_SEQ [5] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    // Helpers work in a 64-bit container holding an n-bit word in its low bits.
    function automatic logic [63:0] word_mask(input int unsigned n);
        return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned s,
                                         input int unsigned n);
        return ((v << s) | (v >> (n - s))) & word_mask(n);
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned s,
                                         input int unsigned n);
        return rotl(v, n - s, n);
    endfunction

    function automatic logic [63:0] simon_f(input logic [63:0] v, input int unsigned n);
        return (rotl(v, 1, n) & rotl(v, 8, n)) ^ rotl(v, 2, n);
    endfunction

    function automatic logic z_bit(input int unsigned zi, input int unsigned j);
        logic [61:0] zs;
        zs = Z_SEQ[3'(zi)];
        return zs[6'(61 - j)];
    endfunction

endpackage

// File: rtl/simon_key_sched.sv
// SIMON round-key store with in-place key expansion; macro SIMON_ZEROIZE_EN adds a reset clear of the store.
module simon_key_sched
    import simon_pkg::*;
#(
    parameter int unsigned N  = 64,
    parameter int unsigned M  = 2,
    parameter int unsigned T  = 68,
    parameter int unsigned ZI = 2,
    parameter int unsigned IW = 7
) (
    input  logic                clk,
`ifdef SIMON_ZEROIZE_EN
    input  logic                rst_n,
`endif
    input  logic                load,
    input  logic [M-1:0][N-1:0] key,
    input  logic                exp_en,
    input  logic [IW-1:0]       exp_idx,
    input  logic [IW-1:0]       rd_idx,
    output logic [N-1:0]        rd_key
);
    logic [N-1:0] ks [T];
    logic [N-1:0] tmp;
    logic [N-1:0] next_key;
    int unsigned  zj;

    // exp_idx is the index i of the key being produced this cycle.
    always_comb begin
        tmp = N'(rotr(64'(ks[exp_idx - IW'(1)]), 3, N));
        if (M == 4) begin
            tmp = tmp ^ ks[exp_idx - IW'(3)];
        end
        tmp = tmp ^ N'(rotr(64'(tmp), 1, N));
        zj  = 32'(exp_idx) - M;
        if (zj >= 62) begin
            zj = zj - 62;
        end
        next_key = ~ks[exp_idx - IW'(M)] ^ tmp ^ N'(z_bit(ZI, zj)) ^ N'(3);
    end

`ifdef SIMON_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < T; i++) begin
                ks[i] <= '0;
            end
        end else if (load) begin
            for (int unsigned w = 0; w < M; w++) begin
                ks[w] <= key[w];
            end
        end else if (exp_en) begin
            ks[exp_idx] <= next_key;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (load) begin
            for (int unsigned w = 0; w < M; w++) begin
                ks[w] <= key[w];
            end
        end else if (exp_en) begin
            ks[exp_idx] <= next_key;
        end
    end
`endif

    assign rd_key = ks[rd_idx];

endmodule

// File: rtl/simon_param_core.sv
// Iterative SIMON 2N/MN core, one round per clock, round keys kept on chip for enc and dec.
// Optional macro SIMON_ZEROIZE_EN clears the result and state after read-out and the key store on reset.
module simon_param_core
    import simon_pkg::*;
#(
    parameter int unsigned N  = 64,
    parameter int unsigned M  = 2,
    parameter int unsigned T  = 68,
    parameter int unsigned ZI = 2
) (
    input  logic                clk,
    input  logic                nR,
    input  logic                newData,
    input  logic                newKey,
    input  logic                enc_dec,
    input  logic                readData,
    input  logic [1:0][N-1:0]   BLOCK,
    input  logic [M-1:0][N-1:0] KEY,
    output logic                loadData,
    output logic                loadKey,
    output logic                doneData,
    output logic                doneKey,
    output logic [1:0][N-1:0]   outData,
    output logic [3:0]          mode
);
    localparam int unsigned IW = $clog2(T);

    state_t        state;
    logic [IW-1:0] cnt;
    logic [IW-1:0] rd_idx;
    logic          enc;
    logic [N-1:0]  x;
    logic [N-1:0]  y;
    logic [N-1:0]  nx;
    logic [N-1:0]  ny;
    logic [N-1:0]  rk;

    simon_key_sched #(.N(N), .M(M), .T(T), .ZI(ZI), .IW(IW)) u_key_sched (
        .clk     (clk),
`ifdef SIMON_ZEROIZE_EN
        .rst_n   (nR),
`endif
        .load    (state == ST_KLOAD),
        .key     (KEY),
        .exp_en  (state == ST_KEXP),
        .exp_idx (cnt),
        .rd_idx  (rd_idx),
        .rd_key  (rk)
    );

    // Decryption runs the encrypt round on a swapped block with keys in reverse order.
    always_comb begin
        rd_idx = enc ? cnt : IW'(T - 1) - cnt;
        nx     = y ^ N'(simon_f(64'(x), N)) ^ rk;
        ny     = x;
    end

    assign loadKey  = (state == ST_KLOAD);
    assign loadData = (state == ST_DLOAD);
    assign mode     = state;

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            enc      <= 1'b0;
            x        <= '0;
            y        <= '0;
            doneKey  <= 1'b0;
            doneData <= 1'b0;
            outData  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (newKey) begin
                        doneKey <= 1'b0;
                        state   <= ST_KLOAD;
                    end else if (newData && doneKey) begin
                        state <= ST_DLOAD;
                    end
                end
                ST_KLOAD: begin
                    cnt   <= IW'(M);
                    state <= ST_KEXP;
                end
                ST_KEXP: begin
                    if (cnt == IW'(T - 1)) begin
                        doneKey <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DLOAD: begin
                    enc   <= enc_dec;
                    x     <= enc_dec ? BLOCK[1] : BLOCK[0];
                    y     <= enc_dec ? BLOCK[0] : BLOCK[1];
                    cnt   <= '0;
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    x <= nx;
                    y <= ny;
                    if (cnt == IW'(T - 1)) begin
                        outData  <= enc ? {nx, ny} : {ny, nx};
                        doneData <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (readData) begin
                        doneData <= 1'b0;
                        state    <= ST_IDLE;
`ifdef SIMON_ZEROIZE_EN
                        outData  <= '0;
                        x        <= '0;
                        y        <= '0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
